// File: rtl/shift_rotate_seq_pkg.sv
// Shared encodings for the shift/rotate sequencer: ALU op codes and FSM states.
package shift_rotate_seq_pkg;

    typedef enum logic [2:0] {
        OP_SHR  = 3'b000,
        OP_SHRA = 3'b001,
        OP_SHL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'b100;
    endfunction

endpackage

// File: rtl/shift_rotate_seq_shift_step.sv
// Combinational single step: shifts/rotates acc by k bits (k <= STEP) for the given op.
module shift_step
    import shift_rotate_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [2:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] res
);

    // k == 0 makes the wrap term shift by WIDTH, which yields zero, so rotates stay correct.
    always_comb begin
        case (op)
            OP_SHR:  res = acc >> k;
            OP_SHRA: res = $unsigned($signed(acc) >>> k);
            OP_SHL:  res = acc << k;
            OP_ROR:  res = (acc >> k) | (acc << (WIDTH - int'(k)));
            OP_ROL:  res = (acc << k) | (acc >> (WIDTH - int'(k)));
            default: res = acc;
        endcase
    end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle SHR/SHRA/SHL/ROR/ROL sequencer, up to STEP bits per RUN cycle.
// Optional SHIFT_SEQ_ABORT_EN adds an abort input that cancels a RUN without done.
module shift_rotate_seq
    import shift_rotate_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] zlow,
    output logic [WIDTH-1:0] zhigh
);

    localparam int KW = $clog2(STEP) + 1;

    state_e           state, state_n;
    logic [WIDTH-1:0] acc, acc_n, step_res, zlow_n;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic [2:0]       op_q, op_n;
    logic             err_n, done_n, busy_n;
    logic [KW-1:0]    k;
    logic             abort_run;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_run = abort;
`else
    assign abort_run = 1'b0;
`endif

    assign k = (cnt >= AMT_W'(STEP)) ? KW'(STEP) : KW'(cnt);

    shift_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .acc (acc),
        .op  (op_q),
        .k   (k),
        .res (step_res)
    );

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        op_n    = op_q;
        zlow_n  = zlow;
        err_n   = err;
        done_n  = 1'b0;
        case (state)
            S_RUN: begin
                if (abort_run) begin
                    state_n = S_IDLE;
                end else if (cnt != '0) begin
                    acc_n = step_res;
                    cnt_n = cnt - AMT_W'(k);
                end else begin
                    zlow_n  = acc;
                    err_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request, giving back-to-back issue.
                if (start && op_legal(op)) begin
                    acc_n   = x;
                    cnt_n   = y[AMT_W-1:0];
                    op_n    = op;
                    state_n = S_RUN;
                end else if (start) begin
                    zlow_n  = '0;
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    state_n = S_IDLE;
                end
            end
        endcase
        busy_n = (state_n == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= '0;
            zlow  <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            zlow  <= zlow_n;
            err   <= err_n;
            done  <= done_n;
            busy  <= busy_n;
        end
    end

    assign zhigh = '0;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed bench for shift_rotate_seq: vector table on STEP=1 and STEP=4 instances plus corner sequences.
module tb_shift_rotate_seq;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] x = '0, y = '0;
    logic        busy, done, err, busy4, done4, err4;
    logic [31:0] zlow, zhigh, zlow4, zhigh4;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    shift_rotate_seq #(.WIDTH(32), .AMT_W(5), .STEP(1)) dut (
        .clock(clock), .clear(clear),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort(abort),
`endif
        .start(start), .op(op), .x(x), .y(y),
        .busy(busy), .done(done), .err(err), .zlow(zlow), .zhigh(zhigh)
    );

    shift_rotate_seq #(.WIDTH(32), .AMT_W(5), .STEP(4)) dut4 (
        .clock(clock), .clear(clear),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort(abort),
`endif
        .start(start), .op(op), .x(x), .y(y),
        .busy(busy4), .done(done4), .err(err4), .zlow(zlow4), .zhigh(zhigh4)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        err;
        int          lat;
        int          lat4;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives a start for one cycle; returns positioned in cycle 1, inputs scrambled.
    task automatic issue(input logic [2:0] o, input logic [31:0] xv, input logic [31:0] yv);
        op = o; x = xv; y = yv; start = 1'b1;
        tick();
        start = 1'b0; op = 3'b010; x = ~xv; y = yv + 32'd3;
    endtask

    // Counts cycles until done on the STEP=1 instance; also notes the STEP=4 done cycle.
    task automatic wait_done(input int c0, output int c, output int c4, output bit busy_ok);
        c = c0; c4 = 0; busy_ok = 1'b1;
        while (c <= 100 && !done) begin
            if (done4 && c4 == 0) c4 = c;
            if (!busy) busy_ok = 1'b0;
            tick();
            c++;
        end
        if (done4 && c4 == 0) c4 = c;
    endtask

    vec_t vt[11];

    initial begin
        int c, c4;
        bit bok;
        int ndone;

        vt[0]  = '{3'b100, 32'h55555555, 32'd7,  32'hAAAAAAAA, 1'b0, 9,  4};
        vt[1]  = '{3'b100, 32'h0000FFFF, 32'd7,  32'h007FFF80, 1'b0, 9,  4};
        vt[2]  = '{3'b011, 32'h0000FFFF, 32'd7,  32'hFE0001FF, 1'b0, 9,  4};
        vt[3]  = '{3'b001, 32'h80000000, 32'd4,  32'hF8000000, 1'b0, 6,  3};
        vt[4]  = '{3'b000, 32'h80000000, 32'd4,  32'h08000000, 1'b0, 6,  3};
        vt[5]  = '{3'b010, 32'h00000001, 32'd31, 32'h80000000, 1'b0, 33, 10};
        vt[6]  = '{3'b111, 32'h12345678, 32'd3,  32'h00000000, 1'b1, 1,  1};
        vt[7]  = '{3'b011, 32'h12345678, 32'd0,  32'h12345678, 1'b0, 2,  2};
        vt[8]  = '{3'b011, 32'h12345678, 32'd32, 32'h12345678, 1'b0, 2,  2};
        vt[9]  = '{3'b001, 32'h40000000, 32'd3,  32'h08000000, 1'b0, 5,  3};
        vt[10] = '{3'b010, 32'h00000003, 32'd33, 32'h00000006, 1'b0, 3,  3};

        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_zlow", zlow, 0);
        chk("rst_zhigh", zhigh, 0);
        clear = 1'b0;
        tick();

        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].x, vt[i].y);
            wait_done(1, c, c4, bok);
            chk($sformatf("v%0d_lat", i), c, vt[i].lat);
            chk($sformatf("v%0d_lat4", i), c4, vt[i].lat4);
            chk($sformatf("v%0d_zlow", i), zlow, vt[i].z);
            chk($sformatf("v%0d_zlow4", i), zlow4, vt[i].z);
            chk($sformatf("v%0d_zhigh", i), zhigh, 0);
            chk($sformatf("v%0d_err", i), err, vt[i].err);
            chk($sformatf("v%0d_busy_run", i), bok, 1);
            chk($sformatf("v%0d_busy_done", i), busy, 0);
            tick();
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // Back-to-back: second start sampled in the DONE cycle of the first.
        issue(3'b011, 32'h12345678, 32'd0);
        wait_done(1, c, c4, bok);
        chk("b2b_first_lat", c, 2);
        issue(3'b100, 32'h0000FFFF, 32'd7);
        wait_done(1, c, c4, bok);
        chk("b2b_second_lat", c, 9);
        chk("b2b_second_zlow", zlow, 32'h007FFF80);
        tick();

        // Start while running is ignored.
        issue(3'b010, 32'h00000001, 32'd4);
        start = 1'b1; op = 3'b011; x = 32'hFFFFFFFF; y = 32'd1;
        tick();
        start = 1'b0;
        wait_done(2, c, c4, bok);
        chk("ign_lat", c, 6);
        chk("ign_zlow", zlow, 32'h00000010);
        tick();

        // Clear in cycle 3 discards the operation.
        issue(3'b010, 32'h00000001, 32'd10);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_zlow", zlow, 0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("clr_no_done", ndone, 0);

`ifdef SHIFT_SEQ_ABORT_EN
        issue(3'b100, 32'h0000FFFF, 32'd7);
        wait_done(1, c, c4, bok);
        tick();
        issue(3'b010, 32'h00000001, 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_busy", busy, 0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("abt_no_done", ndone, 0);
        chk("abt_zlow_kept", zlow, 32'h007FFF80);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
